// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared constants and FSM state type for the Booth multiplier.
//               Optional build macro: MULT_UNSIGNED_EN (widens operands by one
//               bit so unsigned products are supported).
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_STEPS = 32;
  localparam int MULT_CNT_W = $clog2(MULT_STEPS) + 1;

`ifdef MULT_UNSIGNED_EN
  // One extra operand bit lets a zero-extended unsigned value stay positive.
  localparam int MULT_OPW = MULT_WIDTH + 1;
`else
  localparam int MULT_OPW = MULT_WIDTH;
`endif

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    INICIAL  = 2'd1,
    CONTAGEM = 2'd2,
    FIM      = 2'd3
  } mult_state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_booth_step.sv
`default_nettype none
// ============================================================================
// Module      : mult_booth_step
// Description : One combinational radix-2 Booth iteration: conditional
//               add/subtract of the multiplicand into the upper half, then an
//               arithmetic right shift of the whole {hi, lo, q-1} register.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_booth_step
  import mult_pkg::*;
#(
  parameter int OPW = MULT_OPW
) (
  input  logic [OPW-1:0] hi_in,
  input  logic [OPW-1:0] lo_in,
  input  logic           qm1_in,
  input  logic [OPW-1:0] mcand,
  output logic [OPW-1:0] hi_out,
  output logic [OPW-1:0] lo_out,
  output logic           qm1_out
);

  logic [OPW:0] w_hi_ext;
  logic [OPW:0] w_m_ext;
  logic [OPW:0] w_sum;

  // The sum carries one guard bit so that subtracting the most negative
  // multiplicand cannot overflow; the shift then drops it back to OPW bits.
  always_comb begin
    w_hi_ext = {hi_in[OPW-1], hi_in};
    w_m_ext  = {mcand[OPW-1], mcand};
    case ({lo_in[0], qm1_in})
      2'b01:   w_sum = w_hi_ext + w_m_ext;
      2'b10:   w_sum = w_hi_ext - w_m_ext;
      default: w_sum = w_hi_ext;
    endcase
  end

  assign hi_out  = w_sum[OPW:1];
  assign lo_out  = {w_sum[0], lo_in[OPW-1:1]};
  assign qm1_out = lo_in[0];

endmodule : mult_booth_step
`default_nettype wire

// File: rtl/mult_booth.sv
`default_nettype none
// ============================================================================
// Module      : mult_booth
// Description : Sequential 32x32 radix-2 Booth multiplier, fixed 35-edge
//               latency. Optional build macro: MULT_UNSIGNED_EN adds the
//               MULTunsigned input for unsigned products.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_booth
  import mult_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  MULTcontrol,
  input  logic [MULT_WIDTH-1:0] A,
  input  logic [MULT_WIDTH-1:0] B,
`ifdef MULT_UNSIGNED_EN
  input  logic                  MULTunsigned,
`endif
  output logic [MULT_WIDTH-1:0] himult,
  output logic [MULT_WIDTH-1:0] lomult,
  output logic                  MULTdone,
  output logic                  MULTbusy
);

  localparam logic [MULT_CNT_W-1:0] c_last_step = MULT_CNT_W'(MULT_STEPS - 1);

  mult_state_t r_state;
  mult_state_t w_next;

  logic [MULT_CNT_W-1:0] r_count;
  logic [MULT_OPW-1:0]   r_mcand;
  logic [MULT_OPW-1:0]   r_mplier;
  logic [MULT_OPW-1:0]   r_hi;
  logic [MULT_OPW-1:0]   r_lo;
  logic                  r_qm1;
  logic [MULT_WIDTH-1:0] r_himult;
  logic [MULT_WIDTH-1:0] r_lomult;
  logic                  r_done;

  logic [MULT_OPW-1:0]   w_opa;
  logic [MULT_OPW-1:0]   w_opb;
  logic [MULT_OPW-1:0]   w_hi_nx;
  logic [MULT_OPW-1:0]   w_lo_nx;
  logic                  w_qm1_nx;
  logic [2*MULT_OPW-1:0] w_product;

  logic w_accept;
  logic w_load;
  logic w_step;
  logic w_finish;

`ifdef MULT_UNSIGNED_EN
  logic [2*(MULT_OPW-MULT_WIDTH)-1:0] w_unused_top;

  assign w_opa = {(MULTunsigned ? 1'b0 : A[MULT_WIDTH-1]), A};
  assign w_opb = {(MULTunsigned ? 1'b0 : B[MULT_WIDTH-1]), B};
  // A 33-bit multiplier needs 33 Booth steps; the last one is applied
  // combinationally while in FIM so the latency matches the signed build.
  assign w_product    = {w_hi_nx, w_lo_nx};
  assign w_unused_top = w_product[2*MULT_OPW-1:2*MULT_WIDTH];
`else
  assign w_opa     = A;
  assign w_opb     = B;
  assign w_product = {r_hi, r_lo};
`endif

  mult_booth_step #(
    .OPW (MULT_OPW)
  ) u_step (
    .hi_in   (r_hi),
    .lo_in   (r_lo),
    .qm1_in  (r_qm1),
    .mcand   (r_mcand),
    .hi_out  (w_hi_nx),
    .lo_out  (w_lo_nx),
    .qm1_out (w_qm1_nx)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ESPERA;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ESPERA:   if (MULTcontrol) w_next = INICIAL;
      INICIAL:  w_next = CONTAGEM;
      CONTAGEM: if (r_count == c_last_step) w_next = FIM;
      FIM:      w_next = ESPERA;
      default:  w_next = ESPERA;
    endcase
  end

  always_comb begin
    MULTbusy = 1'b0;
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      ESPERA:   w_accept = MULTcontrol;
      INICIAL:  begin MULTbusy = 1'b1; w_load   = 1'b1; end
      CONTAGEM: begin MULTbusy = 1'b1; w_step   = 1'b1; end
      FIM:      begin MULTbusy = 1'b1; w_finish = 1'b1; end
      default:  MULTbusy = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_qm1    <= 1'b0;
      r_himult <= '0;
      r_lomult <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_mcand  <= w_opa;
        r_mplier <= w_opb;
      end
      if (w_load) begin
        r_hi    <= '0;
        r_lo    <= r_mplier;
        r_qm1   <= 1'b0;
        r_count <= '0;
      end
      if (w_step) begin
        r_hi    <= w_hi_nx;
        r_lo    <= w_lo_nx;
        r_qm1   <= w_qm1_nx;
        r_count <= r_count + 1'b1;
      end
      if (w_finish) begin
        r_himult <= w_product[2*MULT_WIDTH-1:MULT_WIDTH];
        r_lomult <= w_product[MULT_WIDTH-1:0];
      end
    end
  end

  assign himult   = r_himult;
  assign lomult   = r_lomult;
  assign MULTdone = r_done;

endmodule : mult_booth
`default_nettype wire

// File: tb/tb_mult_booth.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_booth
// Description : Self-checking bench for mult_booth against an arithmetic
//               product model. Optional build macro: MULT_UNSIGNED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_booth;

  logic        clock;
  logic        reset;
  logic        MULTcontrol;
  logic [31:0] A;
  logic [31:0] B;
`ifdef MULT_UNSIGNED_EN
  logic        MULTunsigned;
`endif
  logic [31:0] himult;
  logic [31:0] lomult;
  logic        MULTdone;
  logic        MULTbusy;

  int checks   = 0;
  int failures = 0;

  mult_booth dut (
    .clock        (clock),
    .reset        (reset),
    .MULTcontrol  (MULTcontrol),
    .A            (A),
    .B            (B),
`ifdef MULT_UNSIGNED_EN
    .MULTunsigned (MULTunsigned),
`endif
    .himult       (himult),
    .lomult       (lomult),
    .MULTdone     (MULTdone),
    .MULTbusy     (MULTbusy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input bit uns);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    if (uns) begin
      ua = a;
      ub = b;
      return ua * ub;
    end
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1ns so outputs are read away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Accept on edge 1, then wait (bounded) for the done pulse.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit uns,
                        output logic [63:0] res, output int done_at);
    A = a;
    B = b;
`ifdef MULT_UNSIGNED_EN
    MULTunsigned = uns;
`endif
    MULTcontrol = 1'b1;
    tick();
    MULTcontrol = 1'b0;
    done_at = -1;
    for (int e = 2; e <= 60 && done_at < 0; e++) begin
      tick();
      if (MULTdone === 1'b1) done_at = e;
    end
    res = {himult, lomult};
  endtask

  logic [63:0] res;
  logic [63:0] res0;
  logic [63:0] res1;
  logic [31:0] ra;
  logic [31:0] rb;
  int          done_at;
  int          pulses;
  int          d0;
  int          d1;
  logic        busy_e35;
  logic        busy_e36;

  initial begin
    reset       = 1'b0;
    MULTcontrol = 1'b0;
    A           = '0;
    B           = '0;
`ifdef MULT_UNSIGNED_EN
    MULTunsigned = 1'b0;
`endif
    tick();
    tick();
    chk("reset_outputs", {himult, lomult}, 64'd0);
    chk("reset_done_busy", {62'd0, MULTdone, MULTbusy}, 64'd0);
    reset = 1'b1;
    tick();

    // 7 * -3 with exact edge timing of the done pulse
    A = 32'd7;
    B = 32'hFFFF_FFFD;
    MULTcontrol = 1'b1;
    tick();
    MULTcontrol = 1'b0;
    chk("busy_after_accept", {63'd0, MULTbusy}, 64'd1);
    done_at = -1;
    for (int e = 2; e <= 34; e++) begin
      tick();
      if (MULTdone === 1'b1 && done_at < 0) done_at = e;
    end
    chk("no_early_done", 64'(done_at), 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("done_at_edge35", {63'd0, MULTdone}, 64'd1);
    chk("prod_7_x_m3", {himult, lomult}, 64'hFFFF_FFFF_FFFF_FFEB);
    tick();
    chk("done_clear_edge36", {63'd0, MULTdone}, 64'd0);
    chk("hold_after_done", {himult, lomult}, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, res, done_at);
    chk("prod_min_x_min", res, 64'h4000_0000_0000_0000);
    chk("lat_min_x_min", 64'(done_at), 64'd35);
    tick();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, done_at);
    chk("prod_m1_x_m1", res, 64'd1);
    tick();

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'h8000_0000;
      if (i == 1) rb = 32'd0;
      run_op(ra, rb, 1'b0, res, done_at);
      chk($sformatf("rand_prod_%0d", i), res, model(ra, rb, 1'b0));
      chk($sformatf("rand_lat_%0d", i), 64'(done_at), 64'd35);
      tick();
    end

`ifdef MULT_UNSIGNED_EN
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, res, done_at);
    chk("uns_max_x_max", res, 64'hFFFF_FFFE_0000_0001);
    chk("uns_lat", 64'(done_at), 64'd35);
    tick();
    ra = $urandom;
    rb = $urandom | 32'h8000_0000;
    run_op(ra, rb, 1'b1, res, done_at);
    chk("uns_rand", res, model(ra, rb, 1'b1));
    tick();
    run_op(ra, rb, 1'b0, res, done_at);
    chk("uns_build_signed", res, model(ra, rb, 1'b0));
    tick();
`endif

    // Late operand change and an ignored second start request
    A = 32'd5;
    B = 32'd6;
    MULTcontrol = 1'b1;
    tick();
    MULTcontrol = 1'b0;
    pulses  = 0;
    done_at = -1;
    for (int e = 2; e <= 80; e++) begin
      if (e == 5) B = 32'd77;
      if (e == 10) begin
        MULTcontrol = 1'b1;
        A = 32'd9;
      end
      if (e == 11) MULTcontrol = 1'b0;
      tick();
      if (MULTdone === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = e;
      end
    end
    chk("ignored_start_pulses", 64'(pulses), 64'd1);
    chk("ignored_start_lat", 64'(done_at), 64'd35);
    chk("ignored_start_prod", {himult, lomult}, 64'd30);

    // Asynchronous reset in the middle of an operation
    A = 32'h1234_5678;
    B = 32'h0000_0100;
    MULTcontrol = 1'b1;
    tick();
    MULTcontrol = 1'b0;
    for (int e = 2; e <= 20; e++) tick();
    #1 reset = 1'b0;
    #1;
    chk("async_reset_outputs", {himult, lomult}, 64'd0);
    chk("async_reset_flags", {62'd0, MULTdone, MULTbusy}, 64'd0);
    tick();
    tick();
    reset = 1'b1;
    pulses = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (MULTdone === 1'b1) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    chk("abort_outputs_zero", {himult, lomult}, 64'd0);
    run_op(32'd3, 32'd4, 1'b0, res, done_at);
    chk("after_reset_prod", res, 64'd12);
    chk("after_reset_lat", 64'(done_at), 64'd35);
    tick();

    // Start held high: the next operation is accepted on the edge after FIM
    ra = $urandom;
    rb = $urandom;
    A = ra;
    B = rb;
    MULTcontrol = 1'b1;
    tick();
    A = ~ra;
    B = rb ^ 32'h00FF_00FF;
    d0 = -1;
    d1 = -1;
    busy_e35 = 1'bx;
    busy_e36 = 1'bx;
    res0 = '0;
    res1 = '0;
    for (int e = 2; e <= 100 && d1 < 0; e++) begin
      tick();
      if (e == 35) busy_e35 = MULTbusy;
      if (e == 36) busy_e36 = MULTbusy;
      if (MULTdone === 1'b1) begin
        if (d0 < 0) begin
          d0 = e;
          res0 = {himult, lomult};
        end else begin
          d1 = e;
          res1 = {himult, lomult};
          MULTcontrol = 1'b0;
        end
      end
    end
    MULTcontrol = 1'b0;
    chk("b2b_first_done", 64'(d0), 64'd35);
    chk("b2b_idle_after_fim", {63'd0, busy_e35}, 64'd0);
    chk("b2b_accept_edge36", {63'd0, busy_e36}, 64'd1);
    // Second accept is edge 36, so its FIM lands 35 edges after the first one.
    chk("b2b_second_done", 64'(d1), 64'd70);
    chk("b2b_first_prod", res0, model(ra, rb, 1'b0));
    chk("b2b_second_prod", res1, model(~ra, rb ^ 32'h00FF_00FF, 1'b0));
    tick();
    tick();
    chk("b2b_back_idle", {62'd0, MULTdone, MULTbusy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mult_booth
`default_nettype wire
